uart_tx_cfg: RTL and testbench

Parametrised serial transmitter: the next generation of the fixed 8N1 UART transmitter. It adds configurable data width, parity, stop bits, an internal baud divider and a small transmit FIFO, so that several bytes can be queued and sent back-to-back. It sits between a host-side byte producer (start/data/ready strobe interface) and the TX pin.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_tx_cfg_if.sv | 11 +
 rtl/uart_tx_fifo.sv | 57 +++++
 rtl/uart_tx_cfg.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter: parity modes,
// transmit FSM encoding and a frame-length helper.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    // Clock cycles from the first edge of the start bit to the end of the last stop bit.
    function automatic int frame_len(input int data_bits, input int parity,
                                     input int stop_bits, input int clks_per_bit);
        return (1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits) * clks_per_bit;
    endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Host-side write port of the transmitter: word strobe, payload and FIFO-not-full.
interface uart_tx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic                 start;
    logic [DATA_BITS-1:0] data;
    logic                 ready;

    modport master (output start, output data, input ready);
    modport slave  (input start, input data, output ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO queueing words between the host and the transmit shift register.
// Writes when full and reads when empty are ignored; full/empty come from the
// registered occupancy only.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr,
    input  logic                   rd,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full  = (level == (AW + 1)'(DEPTH));
    assign empty = (level == '0);
    assign do_wr = wr && !full;
    assign do_rd = rd && !empty;
    assign dout  = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage array write port.
    // NOTE: storage has no reset; the cleared pointers make stale contents unreachable.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable serial transmitter: start bit, DATA_BITS payload LSB first,
// optional parity, STOP_BITS stop bits. Words are queued in a small FIFO and
// frames follow each other with no idle gap while the FIFO holds data.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    uart_tx_cfg_if.slave                host,
    output logic                        q,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] level
);

    localparam int                BAUD_W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]        LAST_DATA   = 4'(DATA_BITS - 1);
    localparam logic [3:0]        LAST_STOP   = 4'(STOP_BITS - 1);
    localparam logic              PAR_INV     = (PARITY == PAR_ODD);

    tx_state_t            state;
    tx_state_t            state_next;
    logic [BAUD_W-1:0]    baud_cnt;
    logic [BAUD_W-1:0]    baud_next;
    logic [3:0]           bit_cnt;
    logic [3:0]           bit_next;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] shift_next;
    logic                 par_acc;
    logic                 par_next;
    logic                 q_next;
    logic                 bit_end;
    logic                 pop;
    logic [DATA_BITS-1:0] fifo_dout;
    logic                 fifo_full;
    logic                 fifo_empty;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr    (host.start),
        .rd    (pop),
        .din   (host.data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign host.ready = !fifo_full;
    assign bit_end    = (baud_cnt == '0);

    // Transmit state, bit timing, shift register and registered line outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            baud_cnt <= BAUD_RELOAD;
            bit_cnt  <= '0;
            shift    <= '0;
            par_acc  <= 1'b0;
            q        <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_cnt  <= bit_next;
            shift    <= shift_next;
            par_acc  <= par_next;
            q        <= q_next;
            busy     <= (state_next != ST_IDLE);
        end
    end

    // Next-state logic: bit sequencing, FIFO pop and the value q takes after the edge.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case leaves a latch.
        state_next = state;
        baud_next  = bit_end ? BAUD_RELOAD : baud_cnt - BAUD_W'(1);
        bit_next   = bit_cnt;
        shift_next = shift;
        par_next   = par_acc;
        q_next     = q;
        pop        = 1'b0;

        case (state)
            ST_IDLE: begin
                baud_next = BAUD_RELOAD;
                q_next    = 1'b1;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_next = fifo_dout;
                    state_next = ST_START;
                    q_next     = 1'b0;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_next = ST_DATA;
                    bit_next   = '0;
                    q_next     = shift[0];
                    par_next   = shift[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_cnt == LAST_DATA) begin
                        bit_next = '0;
                        if (PARITY != PAR_NONE) begin
                            state_next = ST_PARITY;
                            q_next     = par_acc ^ PAR_INV;
                        end else begin
                            state_next = ST_STOP;
                            q_next     = 1'b1;
                        end
                    end else begin
                        bit_next   = bit_cnt + 4'd1;
                        shift_next = shift >> 1;
                        q_next     = shift[1];
                        par_next   = par_acc ^ shift[1];
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_next = ST_STOP;
                    bit_next   = '0;
                    q_next     = 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (bit_cnt == LAST_STOP) begin
                        if (!fifo_empty) begin
                            pop        = 1'b1;
                            shift_next = fifo_dout;
                            state_next = ST_START;
                            q_next     = 1'b0;
                        end else begin
                            state_next = ST_IDLE;
                            q_next     = 1'b1;
                        end
                    end else begin
                        bit_next = bit_cnt + 4'd1;
                        q_next   = 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                q_next     = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg with three configurations: default 8N1,
// 8E2 at four clocks per bit, and 7O1.
module tb_uart_tx_cfg;

    logic       clk = 1'b0;
    logic       rst;
    logic       d0_q, dp_q, ds_q;
    logic       d0_busy, dp_busy, ds_busy;
    logic [2:0] d0_level, dp_level, ds_level;
    int         n_cmp = 0;
    int         n_bad = 0;

    uart_tx_cfg_if #(.DATA_BITS(8)) if_d ();
    uart_tx_cfg_if #(.DATA_BITS(8)) if_p ();
    uart_tx_cfg_if #(.DATA_BITS(7)) if_s ();

    uart_tx_cfg u_d0 (
        .clk(clk), .rst(rst), .host(if_d), .q(d0_q), .busy(d0_busy), .level(d0_level)
    );

    uart_tx_cfg #(
        .DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .CLKS_PER_BIT(4), .FIFO_DEPTH(4)
    ) u_dp (
        .clk(clk), .rst(rst), .host(if_p), .q(dp_q), .busy(dp_busy), .level(dp_level)
    );

    uart_tx_cfg #(
        .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .CLKS_PER_BIT(1), .FIFO_DEPTH(4)
    ) u_ds (
        .clk(clk), .rst(rst), .host(if_s), .q(ds_q), .busy(ds_busy), .level(ds_level)
    );

    always #5 clk = ~clk;

    // 8N1 line sequence, index 0 first on the wire.
    function automatic logic [9:0] frame8n1(input logic [7:0] d);
        return {1'b1, d, 1'b0};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        if_d.start = 1'b0; if_d.data = '0;
        if_p.start = 1'b0; if_p.data = '0;
        if_s.start = 1'b0; if_s.data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({d0_q, d0_busy, d0_level, if_d.ready} !== {1'b1, 1'b0, 3'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_d0: got q=%b busy=%b level=%0d ready=%b, want 1 0 0 1",
                     d0_q, d0_busy, d0_level, if_d.ready);
        end
        n_cmp++;
        if ({dp_q, dp_busy, dp_level, if_p.ready} !== {1'b1, 1'b0, 3'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_dp: got q=%b busy=%b level=%0d ready=%b, want 1 0 0 1",
                     dp_q, dp_busy, dp_level, if_p.ready);
        end
        n_cmp++;
        if ({ds_q, ds_busy, ds_level, if_s.ready} !== {1'b1, 1'b0, 3'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_ds: got q=%b busy=%b level=%0d ready=%b, want 1 0 0 1",
                     ds_q, ds_busy, ds_level, if_s.ready);
        end
    endtask

    // 0x5A on the default instance: 2-clk latency, 10-bit frame, busy for 10 clk.
    task automatic test_single();
        bit exp_q [10];
        exp_q = '{0, 0, 1, 0, 1, 1, 0, 1, 0, 1};
        @(posedge clk); #1 if_d.start = 1'b1; if_d.data = 8'h5A;
        @(posedge clk); #1 if_d.start = 1'b0;
        n_cmp++;
        if ({d0_q, d0_busy, d0_level} !== {1'b1, 1'b0, 3'd1}) begin
            n_bad++;
            $display("FAIL single_write_edge: got q=%b busy=%b level=%0d, want 1 0 1",
                     d0_q, d0_busy, d0_level);
        end
        for (int c = 1; c <= 11; c++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (c <= 10) begin
                if ({d0_q, d0_busy} !== {exp_q[c-1], 1'b1}) begin
                    n_bad++;
                    $display("FAIL single_bit[%0d]: got q=%b busy=%b, want q=%b busy=1",
                             c - 1, d0_q, d0_busy, exp_q[c-1]);
                end
            end else if ({d0_q, d0_busy, d0_level} !== {1'b1, 1'b0, 3'd0}) begin
                n_bad++;
                $display("FAIL single_end: got q=%b busy=%b level=%0d, want 1 0 0",
                         d0_q, d0_busy, d0_level);
            end
        end
    endtask

    // 8E2 at 4 clk/bit: parity 0, two stop bits, 48-clk frame.
    task automatic test_parity_stop2();
        bit exp_b [12];
        exp_b = '{0, 0, 1, 0, 1, 1, 0, 1, 0, 0, 1, 1};
        @(posedge clk); #1 if_p.start = 1'b1; if_p.data = 8'h5A;
        @(posedge clk); #1 if_p.start = 1'b0;
        for (int c = 1; c <= 49; c++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (c <= 48) begin
                if ({dp_q, dp_busy} !== {exp_b[(c-1)/4], 1'b1}) begin
                    n_bad++;
                    $display("FAIL par_cycle[%0d]: got q=%b busy=%b, want q=%b busy=1",
                             c - 1, dp_q, dp_busy, exp_b[(c-1)/4]);
                end
            end else if ({dp_q, dp_busy} !== {1'b1, 1'b0}) begin
                n_bad++;
                $display("FAIL par_end: got q=%b busy=%b, want 1 0", dp_q, dp_busy);
            end
        end
    endtask

    // 7O1 with 0x41: data 1,0,0,0,0,0,1 and odd parity bit 1.
    task automatic test_data7_odd();
        bit exp_b [10];
        exp_b = '{0, 1, 0, 0, 0, 0, 0, 1, 1, 1};
        @(posedge clk); #1 if_s.start = 1'b1; if_s.data = 7'h41;
        @(posedge clk); #1 if_s.start = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (c <= 10) begin
                if ({ds_q, ds_busy} !== {exp_b[c-1], 1'b1}) begin
                    n_bad++;
                    $display("FAIL d7_bit[%0d]: got q=%b busy=%b, want q=%b busy=1",
                             c - 1, ds_q, ds_busy, exp_b[c-1]);
                end
            end else if ({ds_q, ds_busy} !== {1'b1, 1'b0}) begin
                n_bad++;
                $display("FAIL d7_end: got q=%b busy=%b, want 1 0", ds_q, ds_busy);
            end
        end
    endtask

    // Six writes on consecutive edges: five accepted, 0x06 dropped, five frames back-to-back.
    task automatic test_fifo_full();
        logic [2:0] exp_lvl [6];
        logic       exp_rdy [6];
        logic [9:0] fr;
        exp_lvl = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        @(posedge clk); #1 if_d.start = 1'b1; if_d.data = 8'h01;
        for (int e = 1; e <= 53; e++) begin
            @(posedge clk); #1;
            if (e <= 6) begin
                n_cmp++;
                if ({d0_level, if_d.ready} !== {exp_lvl[e-1], exp_rdy[e-1]}) begin
                    n_bad++;
                    $display("FAIL fifo_wr[%0d]: got level=%0d ready=%b, want level=%0d ready=%b",
                             e, d0_level, if_d.ready, exp_lvl[e-1], exp_rdy[e-1]);
                end
            end
            if (e >= 2 && e <= 51) begin
                fr = frame8n1(8'((e - 2) / 10 + 1));
                n_cmp++;
                if ({d0_q, d0_busy} !== {fr[(e-2)%10], 1'b1}) begin
                    n_bad++;
                    $display("FAIL fifo_stream[%0d]: got q=%b busy=%b, want q=%b busy=1",
                             e - 2, d0_q, d0_busy, fr[(e-2)%10]);
                end
            end
            if (e == 52) begin
                n_cmp++;
                if ({d0_q, d0_busy, d0_level} !== {1'b1, 1'b0, 3'd0}) begin
                    n_bad++;
                    $display("FAIL fifo_end: got q=%b busy=%b level=%0d, want 1 0 0",
                             d0_q, d0_busy, d0_level);
                end
            end
            if (e < 6) if_d.data = 8'(e + 1);
            if (e == 6) if_d.start = 1'b0;
        end
    endtask

    // Reset during data bit 3 with two words queued, then idle line, then a clean frame.
    task automatic test_reset_midframe();
        @(posedge clk); #1 if_d.start = 1'b1; if_d.data = 8'h5A;
        @(posedge clk); #1 if_d.data = 8'h33;
        @(posedge clk); #1 if_d.data = 8'h44;
        @(posedge clk); #1 if_d.start = 1'b0;
        n_cmp++;
        if ({d0_busy, d0_level} !== {1'b1, 3'd2}) begin
            n_bad++;
            $display("FAIL rstmid_queued: got busy=%b level=%0d, want 1 2", d0_busy, d0_level);
        end
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_cmp++;
        if ({d0_q, d0_busy, d0_level, if_d.ready} !== {1'b1, 1'b0, 3'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL rstmid_async: got q=%b busy=%b level=%0d ready=%b, want 1 0 0 1",
                     d0_q, d0_busy, d0_level, if_d.ready);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({d0_q, d0_busy, d0_level} !== {1'b1, 1'b0, 3'd0}) begin
                n_bad++;
                $display("FAIL rstmid_idle[%0d]: got q=%b busy=%b level=%0d, want 1 0 0",
                         c, d0_q, d0_busy, d0_level);
            end
        end
        test_single();
    endtask

    // Write landing on the edge that ends the last stop bit: one idle cycle, then a clean frame.
    task automatic test_stop_edge_write();
        logic [9:0] fa;
        logic [9:0] fb;
        fa = frame8n1(8'h5A);
        fb = frame8n1(8'hC3);
        @(posedge clk); #1 if_d.start = 1'b1; if_d.data = 8'h5A;
        @(posedge clk); #1 if_d.start = 1'b0;
        for (int e = 1; e <= 22; e++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (e <= 10) begin
                if ({d0_q, d0_busy} !== {fa[e-1], 1'b1}) begin
                    n_bad++;
                    $display("FAIL edge_a[%0d]: got q=%b busy=%b, want q=%b busy=1",
                             e - 1, d0_q, d0_busy, fa[e-1]);
                end
            end else if (e == 11) begin
                if ({d0_q, d0_busy, d0_level} !== {1'b1, 1'b0, 3'd1}) begin
                    n_bad++;
                    $display("FAIL edge_gap: got q=%b busy=%b level=%0d, want 1 0 1",
                             d0_q, d0_busy, d0_level);
                end
            end else if (e <= 21) begin
                if ({d0_q, d0_busy} !== {fb[e-12], 1'b1}) begin
                    n_bad++;
                    $display("FAIL edge_b[%0d]: got q=%b busy=%b, want q=%b busy=1",
                             e - 12, d0_q, d0_busy, fb[e-12]);
                end
            end else if ({d0_q, d0_busy, d0_level} !== {1'b1, 1'b0, 3'd0}) begin
                n_bad++;
                $display("FAIL edge_end: got q=%b busy=%b level=%0d, want 1 0 0",
                         d0_q, d0_busy, d0_level);
            end
            if (e == 10) begin
                if_d.start = 1'b1;
                if_d.data  = 8'hC3;
            end
            if (e == 11) if_d.start = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_parity_stop2();
        test_data7_odd();
        test_fifo_full();
        test_reset_midframe();
        test_stop_edge_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
